ps2_scan_decoder: RTL and testbench

- Downstream consumer of the PS/2 keyboard receiver FIFO.
- Pops raw scan-code bytes using the receiver's ready/nextdata_n handshake.
- Folds E0 (extended) and F0 (break) prefixes into single key events and tracks shift state and typematic repeats.
- Presents events with an ASCII translation on a valid/ready stream for the display/console logic.

---
 rtl/ps2_scan_decoder.sv | 145 ++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: pops receiver bytes, folds E0/F0 prefixes
// into key events with shift, repeat and ASCII translation.
module ps2_scan_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             ev_repeat,
    output logic [7:0]       ev_ascii,
    output logic             shift_held,
    output logic [CNT_W-1:0] key_count,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, POP, DECODE, EMIT} state_t;

    state_t     state, state_nx;
    logic [7:0] byte_r;
    logic       ext_pend, brk_pend;
    logic [8:0] last_key;
    logic       last_vld;
    logic       shl, shr;
    logic       is_pfx, press, hit;
    logic [8:0] key;

    function automatic logic [7:0] to_ascii(input logic [7:0] c,
                                            input logic up);
        logic [7:0] a;
        a = 8'h00;
        case (c)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63;
            8'h23: a = 8'h64; 8'h24: a = 8'h65; 8'h2B: a = 8'h66;
            8'h34: a = 8'h67; 8'h33: a = 8'h68; 8'h43: a = 8'h69;
            8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F;
            8'h4D: a = 8'h70; 8'h15: a = 8'h71; 8'h2D: a = 8'h72;
            8'h1B: a = 8'h73; 8'h2C: a = 8'h74; 8'h3C: a = 8'h75;
            8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32;
            8'h26: a = 8'h33; 8'h25: a = 8'h34; 8'h2E: a = 8'h35;
            8'h36: a = 8'h36; 8'h3D: a = 8'h37; 8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        if (up && a >= 8'h61 && a <= 8'h7A)
            a = a - 8'h20;
        return a;
    endfunction

    assign is_pfx     = (byte_r == 8'hE0) || (byte_r == 8'hF0);
    assign press      = !brk_pend;
    assign key        = {ext_pend, byte_r};
    assign hit        = last_vld && (last_key == key);
    assign shift_held = shl | shr;

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: one pop per decode, hold in EMIT until accepted
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (kbd_ready) state_nx = POP;
            POP:     state_nx = DECODE;
            DECODE:  state_nx = is_pfx ? IDLE : EMIT;
            EMIT:    if (ev_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        ev_valid = (state == EMIT);
    end

    // Byte capture, pop strobe, prefix folding and event fields
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            byte_r         <= 8'h00;
            kbd_nextdata_n <= 1'b1;
            ext_pend       <= 1'b0;
            brk_pend       <= 1'b0;
            last_key       <= 9'h000;
            last_vld       <= 1'b0;
            shl            <= 1'b0;
            shr            <= 1'b0;
            ev_code        <= 8'h00;
            ev_ext         <= 1'b0;
            ev_break       <= 1'b0;
            ev_repeat      <= 1'b0;
            ev_ascii       <= 8'h00;
            key_count      <= '0;
        end else begin
            kbd_nextdata_n <= !(state == IDLE && kbd_ready);
            if (state == IDLE && kbd_ready)
                byte_r <= kbd_data;
            if (state == DECODE) begin
                if (byte_r == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (byte_r == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ev_code   <= byte_r;
                    ev_ext    <= ext_pend;
                    ev_break  <= brk_pend;
                    ev_repeat <= press && hit;
                    ev_ascii  <= (press && !ext_pend)
                               ? to_ascii(byte_r, shl | shr) : 8'h00;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                    if (press && !hit) begin
                        last_key  <= key;
                        last_vld  <= 1'b1;
                        key_count <= key_count + 1'b1;
                    end
                    if (!press && hit)
                        last_vld <= 1'b0;
                    if (!ext_pend && byte_r == 8'h12) shl <= press;
                    if (!ext_pend && byte_r == 8'h59) shr <= press;
                end
            end
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)             err <= 1'b0;
        else if (kbd_overflow) err <= 1'b1;
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: a queue-based receiver model
// feeds bytes, a monitor checks each accepted event against expectations.
module tb_ps2_scan_decoder;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready = 1'b0;
    logic       kbd_overflow = 1'b0;
    logic       kbd_nextdata_n;
    logic       ev_valid;
    logic       ev_ready = 1'b1;
    logic [7:0] ev_code;
    logic       ev_ext, ev_break, ev_repeat;
    logic [7:0] ev_ascii;
    logic       shift_held;
    logic [7:0] key_count;
    logic       err;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int bad_pop = 0;
    logic prev_low = 1'b0;

    logic [7:0]  fifo[$];
    logic [18:0] exp_q[$];

    ps2_scan_decoder #(.CNT_W(8)) dut (
        .clk(clk), .clrn(clrn),
        .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .ev_repeat(ev_repeat), .ev_ascii(ev_ascii),
        .shift_held(shift_held), .key_count(key_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [18:0] ev(input logic [7:0] c, input logic x,
                                       input logic b, input logic r,
                                       input logic [7:0] a);
        return {c, x, b, r, a};
    endfunction

    // Receiver model: pops on a low strobe, flags double/empty pops
    always @(negedge clk) begin
        if (!kbd_nextdata_n) begin
            pop_cnt++;
            if (prev_low || fifo.size() == 0) bad_pop++;
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        prev_low  = !kbd_nextdata_n;
        kbd_ready = (fifo.size() != 0);
        kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    // Monitor: compare every accepted event with the scoreboard head
    always @(negedge clk) begin
        if (ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %0h expected none",
                         {ev_code, ev_ext, ev_break, ev_repeat, ev_ascii});
            end else begin
                check("event",
                      {13'd0, ev_code, ev_ext, ev_break, ev_repeat, ev_ascii},
                      {13'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0 || ev_valid)
               && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int unstable;
        repeat (3) @(posedge clk);
        #1;
        check("rst_nextdata_n", kbd_nextdata_n, 1);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_fields",
              {ev_code, ev_ext, ev_break, ev_repeat, ev_ascii}, 0);
        check("rst_shift", shift_held, 0);
        check("rst_key_count", key_count, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        // Press and release of A
        pop_cnt = 0;
        send(8'h1C); send(8'hF0); send(8'h1C);
        exp_q.push_back(ev(8'h1C, 0, 0, 0, 8'h61));
        exp_q.push_back(ev(8'h1C, 0, 1, 0, 8'h00));
        drain();
        check("t1_key_count", key_count, 1);
        check("t1_pops", pop_cnt, 3);
        check("t1_bad_pops", bad_pop, 0);

        // Shifted A
        send(8'h12);
        exp_q.push_back(ev(8'h12, 0, 0, 0, 8'h00));
        drain();
        check("t2_shift_on", shift_held, 1);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        exp_q.push_back(ev(8'h1C, 0, 0, 0, 8'h41));
        exp_q.push_back(ev(8'h1C, 0, 1, 0, 8'h00));
        exp_q.push_back(ev(8'h12, 0, 1, 0, 8'h00));
        drain();
        check("t2_shift_off", shift_held, 0);
        check("t2_key_count", key_count, 3);

        // Extended key press and release
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        exp_q.push_back(ev(8'h75, 1, 0, 0, 8'h00));
        exp_q.push_back(ev(8'h75, 1, 1, 0, 8'h00));
        drain();
        check("t3_key_count", key_count, 4);

        // Typematic repeats
        send(8'h1C); send(8'h1C); send(8'h1C);
        exp_q.push_back(ev(8'h1C, 0, 0, 0, 8'h61));
        exp_q.push_back(ev(8'h1C, 0, 0, 1, 8'h61));
        exp_q.push_back(ev(8'h1C, 0, 0, 1, 8'h61));
        drain();
        check("t4_key_count_rep", key_count, 5);
        send(8'hF0); send(8'h1C); send(8'h1C);
        exp_q.push_back(ev(8'h1C, 0, 1, 0, 8'h00));
        exp_q.push_back(ev(8'h1C, 0, 0, 0, 8'h61));
        drain();
        check("t4_key_count", key_count, 6);

        // Backpressure with four queued bytes
        ev_ready = 1'b0;
        pop_cnt = 0;
        unstable = 0;
        send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        exp_q.push_back(ev(8'h32, 0, 0, 0, 8'h62));
        exp_q.push_back(ev(8'h21, 0, 0, 0, 8'h63));
        exp_q.push_back(ev(8'h23, 0, 0, 0, 8'h64));
        exp_q.push_back(ev(8'h24, 0, 0, 0, 8'h65));
        repeat (20) begin
            @(negedge clk);
            if (ev_valid && {ev_code, ev_ascii} != 16'h3262) unstable++;
        end
        check("t5_stall_pops", pop_cnt, 1);
        check("t5_stall_valid", ev_valid, 1);
        check("t5_stall_stable", unstable, 0);
        check("t5_fifo_left", fifo.size(), 3);
        @(posedge clk);
        #1;
        ev_ready = 1'b1;
        drain();
        check("t5_pops", pop_cnt, 4);
        check("t5_key_count", key_count, 10);

        // Reset after partial E0 F0 prefix
        send(8'hE0); send(8'hF0);
        repeat (12) @(posedge clk);
        #1;
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_count", key_count, 0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        send(8'h16);
        exp_q.push_back(ev(8'h16, 0, 0, 0, 8'h31));
        drain();
        check("t6_err", err, 0);
        check("t6_key_count", key_count, 1);

        // Overflow latching
        kbd_overflow = 1'b1;
        @(posedge clk);
        #1;
        kbd_overflow = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t7_err_set", err, 1);
        repeat (10) @(posedge clk);
        #1;
        check("t7_err_sticky", err, 1);
        clrn = 1'b0;
        @(posedge clk);
        #1;
        check("t7_err_clr", err, 0);
        clrn = 1'b1;
        check("bad_pops", bad_pop, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
